// File: rtl/async_fifo_pkg.sv
// Shared async FIFO definitions: default address width, derived pointer width,
// and Gray/binary conversion helpers.
package async_fifo_pkg;

   localparam int unsigned ADDR_W_DEF = 2;
   localparam int unsigned PTR_W_DEF  = ADDR_W_DEF + 1;

   function automatic int unsigned ptr_w(input int unsigned addr_w);
      return addr_w + 1;
   endfunction

   // Operands are zero-extended to 32 bits; callers cast the result back to pointer width.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
      logic [31:0] gm;
      logic [31:0] b;
      gm = (w >= 32) ? g : (g & ((32'd1 << w) - 32'd1));
      b  = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         b[i] = ^(gm >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_wptr_cmp.sv
// Combinational full / almost-full compare of the next write pointer against the
// synchronized Gray read pointer. Almost-full decode built only with GRAY_WPTR_ALMOST_FULL_EN.
module gray_wptr_cmp
   import async_fifo_pkg::*;
#(
   parameter int unsigned PTR_W = PTR_W_DEF
) (
   input  logic [PTR_W-1:0] ptr_gray_next,
`ifdef GRAY_WPTR_ALMOST_FULL_EN
   input  logic [PTR_W-1:0] ptr_bin_next,
   output logic             afull_match,
`endif
   input  logic [PTR_W-1:0] rptr_gray_sync,
   output logic             full_match
);

   // Full when the two MSBs differ and the rest match; in Gray code that is an
   // inversion of the top two bits. With the mask cleared this becomes the empty compare.
   localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);

   assign full_match = (ptr_gray_next == (rptr_gray_sync ^ FULL_MASK));

`ifdef GRAY_WPTR_ALMOST_FULL_EN
   localparam logic [PTR_W-1:0] AFULL_TH = PTR_W'((1 << (PTR_W - 1)) - 1);

   logic [PTR_W-1:0] rbin;
   logic [PTR_W-1:0] fill;

   assign rbin        = PTR_W'(gray2bin(32'(rptr_gray_sync), PTR_W));
   assign fill        = ptr_bin_next - rbin;
   assign afull_match = (fill >= AFULL_TH);
`endif

endmodule

// File: rtl/gray_wptr_encoder.sv
// Write-domain pointer generator for the async FIFO: binary RAM address, registered
// Gray pointer for the read domain, registered full. Option: GRAY_WPTR_ALMOST_FULL_EN.
module gray_wptr_encoder
   import async_fifo_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic                clk_wr,
   input  logic                rst_wr_n,
   input  logic                wr_req,
   input  logic [ADDR_W:0]     rptr_gray_sync,
   output logic                wr_en,
   output logic [ADDR_W-1:0]   waddr,
   output logic [ADDR_W:0]     wptr_gray,
   output logic                full,
   output logic                almost_full
);

   localparam int unsigned PTR_W = ptr_w(ADDR_W);

   logic [PTR_W-1:0] wbin;
   logic [PTR_W-1:0] wgray;
   logic [PTR_W-1:0] wbin_next;
   logic [PTR_W-1:0] wgray_next;
   logic             full_q;
   logic             full_match;

   assign wr_en      = wr_req & ~full_q;
   assign wbin_next  = wbin + PTR_W'(wr_en);
   // Gray register loads from the next-binary conversion so only one bit toggles per write.
   assign wgray_next = PTR_W'(bin2gray(32'(wbin_next)));

`ifdef GRAY_WPTR_ALMOST_FULL_EN
   logic afull_q;
   logic afull_match;

   gray_wptr_cmp #(
      .PTR_W (PTR_W)
   ) u_cmp (
      .ptr_gray_next  (wgray_next),
      .ptr_bin_next   (wbin_next),
      .afull_match    (afull_match),
      .rptr_gray_sync (rptr_gray_sync),
      .full_match     (full_match)
   );

   always_ff @(posedge clk_wr) begin
      if (!rst_wr_n) begin
         afull_q <= 1'b0;
      end else begin
         afull_q <= afull_match;
      end
   end

   assign almost_full = afull_q;
`else
   gray_wptr_cmp #(
      .PTR_W (PTR_W)
   ) u_cmp (
      .ptr_gray_next  (wgray_next),
      .rptr_gray_sync (rptr_gray_sync),
      .full_match     (full_match)
   );

   assign almost_full = 1'b0;
`endif

   always_ff @(posedge clk_wr) begin
      if (!rst_wr_n) begin
         wbin   <= '0;
         wgray  <= '0;
         full_q <= 1'b0;
      end else begin
         wbin   <= wbin_next;
         wgray  <= wgray_next;
         full_q <= full_match;
      end
   end

   assign waddr     = wbin[ADDR_W-1:0];
   assign wptr_gray = wgray;
   assign full      = full_q;

endmodule

// File: tb/tb_gray_wptr_encoder.sv
// Self-checking bench for gray_wptr_encoder (ADDR_W=2) against an occupancy-count model.
module tb_gray_wptr_encoder;

   localparam int unsigned AW = 2;

   logic          clk_wr = 1'b0;
   logic          rst_wr_n;
   logic          wr_req;
   logic [AW:0]   rptr_gray_sync;
   logic          wr_en;
   logic [AW-1:0] waddr;
   logic [AW:0]   wptr_gray;
   logic          full;
   logic          almost_full;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: write/read positions modulo 8 and the flags derived from occupancy.
   int m_wptr = 0;
   int m_rptr = 0;
   bit m_full = 1'b0;
   bit m_afull = 1'b0;
   int gray_tab[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

   always #5 clk_wr = ~clk_wr;

   gray_wptr_encoder #(
      .ADDR_W (AW)
   ) dut (
      .clk_wr         (clk_wr),
      .rst_wr_n       (rst_wr_n),
      .wr_req         (wr_req),
      .rptr_gray_sync (rptr_gray_sync),
      .wr_en          (wr_en),
      .waddr          (waddr),
      .wptr_gray      (wptr_gray),
      .full           (full),
      .almost_full    (almost_full)
   );

   function automatic bit exp_afull();
`ifdef GRAY_WPTR_ALMOST_FULL_EN
      return m_afull;
`else
      return 1'b0;
`endif
   endfunction

   task automatic set_rptr(input int r);
      m_rptr = r % 8;
      rptr_gray_sync = 3'(gray_tab[m_rptr]);
   endtask

   task automatic tick();
      int occ;
      @(posedge clk_wr);
      if (!rst_wr_n) begin
         m_wptr  = 0;
         m_full  = 1'b0;
         m_afull = 1'b0;
      end else begin
         if (wr_req && !m_full) m_wptr = (m_wptr + 1) % 8;
         occ     = (m_wptr - m_rptr + 8) % 8;
         m_full  = (occ == 4);
         m_afull = (occ >= 3);
      end
      #1;
   endtask

   task automatic test_reset();
      rst_wr_n = 1'b0;
      wr_req   = 1'b1;
      set_rptr(0);
      tick();
      tick();
      n_checks++;
      if (waddr !== 2'd0) begin n_fail++; $display("FAIL reset_waddr got %0d exp 0", waddr); end
      n_checks++;
      if (wptr_gray !== 3'b000) begin n_fail++; $display("FAIL reset_gray got %b exp 000", wptr_gray); end
      n_checks++;
      if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
      n_checks++;
      if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_afull got %b exp 0", almost_full); end
   endtask

   task automatic test_fill();
      logic [2:0] exp_g [4] = '{3'b001, 3'b011, 3'b010, 3'b110};
      logic [1:0] exp_a [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      rst_wr_n = 1'b1;
      set_rptr(0);
      for (int i = 0; i < 4; i++) begin
         wr_req = 1'b1;
         #1;
         n_checks++;
         if (wr_en !== 1'b1) begin n_fail++; $display("FAIL fill_wr_en[%0d] got %b exp 1", i, wr_en); end
         tick();
         n_checks++;
         if (wptr_gray !== exp_g[i]) begin n_fail++; $display("FAIL fill_gray[%0d] got %b exp %b", i, wptr_gray, exp_g[i]); end
         n_checks++;
         if (waddr !== exp_a[i]) begin n_fail++; $display("FAIL fill_waddr[%0d] got %0d exp %0d", i, waddr, exp_a[i]); end
         n_checks++;
         if (full !== (i == 3)) begin n_fail++; $display("FAIL fill_full[%0d] got %b exp %b", i, full, (i == 3)); end
`ifdef GRAY_WPTR_ALMOST_FULL_EN
         n_checks++;
         if (almost_full !== (i >= 2)) begin n_fail++; $display("FAIL fill_afull[%0d] got %b exp %b", i, almost_full, (i >= 2)); end
`endif
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 3; i++) begin
         wr_req = 1'b1;
         #1;
         n_checks++;
         if (wr_en !== 1'b0) begin n_fail++; $display("FAIL ovf_wr_en[%0d] got %b exp 0", i, wr_en); end
         tick();
         n_checks++;
         if (wptr_gray !== 3'b110) begin n_fail++; $display("FAIL ovf_gray[%0d] got %b exp 110", i, wptr_gray); end
         n_checks++;
         if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full[%0d] got %b exp 1", i, full); end
      end
   endtask

   task automatic test_drain();
      wr_req = 1'b0;
      set_rptr(1);
      tick();
      n_checks++;
      if (full !== 1'b0) begin n_fail++; $display("FAIL drain_full got %b exp 0", full); end
      n_checks++;
      if (almost_full !== exp_afull()) begin n_fail++; $display("FAIL drain_afull got %b exp %b", almost_full, exp_afull()); end
      wr_req = 1'b1;
      #1;
      n_checks++;
      if (wr_en !== 1'b1) begin n_fail++; $display("FAIL drain_wr_en got %b exp 1", wr_en); end
      tick();
      wr_req = 1'b0;
      n_checks++;
      if (wptr_gray !== 3'b111) begin n_fail++; $display("FAIL drain_gray got %b exp 111", wptr_gray); end
      n_checks++;
      if (full !== 1'b1) begin n_fail++; $display("FAIL drain_refull got %b exp 1", full); end
   endtask

   task automatic test_wrap();
      logic [2:0] exp_g [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
      logic [2:0] prev;
      rst_wr_n = 1'b0;
      wr_req   = 1'b0;
      set_rptr(0);
      tick();
      rst_wr_n = 1'b1;
      prev = wptr_gray;
      for (int i = 0; i < 8; i++) begin
         set_rptr(m_wptr);
         wr_req = 1'b1;
         tick();
         n_checks++;
         if (wptr_gray !== exp_g[i]) begin n_fail++; $display("FAIL wrap_gray[%0d] got %b exp %b", i, wptr_gray, exp_g[i]); end
         n_checks++;
         if ($countones(wptr_gray ^ prev) != 1) begin n_fail++; $display("FAIL wrap_hamming[%0d] got %b->%b exp 1 bit change", i, prev, wptr_gray); end
         n_checks++;
         if (full !== 1'b0) begin n_fail++; $display("FAIL wrap_full[%0d] got %b exp 0", i, full); end
         prev = wptr_gray;
      end
      wr_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      set_rptr(m_wptr);
      for (int i = 0; i < 3; i++) begin
         wr_req = 1'b1;
         tick();
      end
      n_checks++;
      if (waddr !== 2'(m_wptr % 4)) begin n_fail++; $display("FAIL mid_pre_waddr got %0d exp %0d", waddr, m_wptr % 4); end
      rst_wr_n = 1'b0;
      tick();
      set_rptr(0);
      n_checks++;
      if (waddr !== 2'd0 || wptr_gray !== 3'b000 || full !== 1'b0 || almost_full !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset got waddr=%0d gray=%b full=%b af=%b exp all 0", waddr, wptr_gray, full, almost_full);
      end
      rst_wr_n = 1'b1;
      tick();
      n_checks++;
      if (waddr !== 2'd1 || wptr_gray !== 3'b001) begin
         n_fail++;
         $display("FAIL mid_resume got waddr=%0d gray=%b exp 1/001", waddr, wptr_gray);
      end
      wr_req = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 63) == 0) begin
            rst_wr_n = 1'b0;
            set_rptr(0);
         end else begin
            rst_wr_n = 1'b1;
            if (m_rptr != m_wptr && $urandom_range(0, 2) == 0) set_rptr(m_rptr + 1);
         end
         wr_req = ($urandom_range(0, 3) != 0);
         #1;
         if (rst_wr_n) begin
            n_checks++;
            if (wr_en !== (wr_req && !m_full)) begin n_fail++; $display("FAIL rnd_wr_en[%0d] got %b exp %b", i, wr_en, (wr_req && !m_full)); end
         end
         tick();
         n_checks++;
         if (waddr !== 2'(m_wptr % 4)) begin n_fail++; $display("FAIL rnd_waddr[%0d] got %0d exp %0d", i, waddr, m_wptr % 4); end
         n_checks++;
         if (wptr_gray !== 3'(gray_tab[m_wptr])) begin n_fail++; $display("FAIL rnd_gray[%0d] got %b exp %b", i, wptr_gray, 3'(gray_tab[m_wptr])); end
         n_checks++;
         if (full !== m_full) begin n_fail++; $display("FAIL rnd_full[%0d] got %b exp %b", i, full, m_full); end
         n_checks++;
         if (almost_full !== exp_afull()) begin n_fail++; $display("FAIL rnd_afull[%0d] got %b exp %b", i, almost_full, exp_afull()); end
      end
      wr_req   = 1'b0;
      rst_wr_n = 1'b1;
   endtask

   initial begin
      rst_wr_n = 1'b0;
      wr_req   = 1'b0;
      set_rptr(0);
      #1;
      test_reset();
      test_fill();
      test_overflow();
      test_drain();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
